// File: rtl/config_int_add_apx_pipe.sv
// config_int_add_apx_pipe: runtime-configurable approximate adder (truncation or lower-part OR)
// built as a segmented carry-ripple pipeline with valid/ready handshakes on both sides.
module config_int_add_apx_pipe #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int SEG_BITWIDTH = 8,
    parameter int TRUNC_STEP = 4,
    parameter int MAX_TRUNC_BITWIDTH = 16,
    parameter int LVL_W = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          apx_ctl,
    input  logic                          apx_mode,
    input  logic [LVL_W-1:0]              apx_lvl,
    input  logic [DATA_PATH_BITWIDTH-1:0] a,
    input  logic [DATA_PATH_BITWIDTH-1:0] b,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0] c,
    output logic                          cout,
    output logic                          ovf
);
    localparam int W = DATA_PATH_BITWIDTH;
    localparam int S = SEG_BITWIDTH;
    localparam int NSEG = W / S;
    localparam int MAX_LVL = MAX_TRUNC_BITWIDTH / TRUNC_STEP;

    logic         adv;
    int           lvl;
    logic [W-1:0] mask_in;
    logic         pv [0:NSEG];
    logic [W-1:0] pc [0:NSEG];
    logic         pcy [0:NSEG];
    logic [W-1:0] pa [0:NSEG-1];
    logic [W-1:0] pb [0:NSEG-1];
    logic [W-1:0] pm [0:NSEG-1];
    logic         pmode [0:NSEG-1];
    logic [W-1:0] nc [1:NSEG];
    logic         ncy [1:NSEG];
    logic         povf;

    assign out_valid = pv[NSEG];
    assign adv = !out_valid || out_ready;
    assign in_ready = adv;
    assign c = pc[NSEG];
    assign cout = pcy[NSEG];
    assign ovf = povf;

    // The truncation setting travels with its operands as a bit mask of the low t bits.
    always_comb begin
        lvl = apx_ctl ? ((int'(apx_lvl) > MAX_LVL) ? MAX_LVL : int'(apx_lvl)) : 0;
        mask_in = ~({W{1'b1}} << (lvl * TRUNC_STEP));
    end

    // Rank s adds segment s; masked bits never generate a carry, so the carry-in of a
    // segment touching the truncated region is always zero.
    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        logic [S-1:0] sa, sb, sm;
        logic [S:0]   sum;
        assign sa = pa[s][s*S +: S];
        assign sb = pb[s][s*S +: S];
        assign sm = pm[s][s*S +: S];
        assign sum = {1'b0, sa & ~sm} + {1'b0, sb & ~sm} + {{S{1'b0}}, pcy[s]};
        assign nc[s+1] = (pc[s] & ~({{(W-S){1'b0}}, {S{1'b1}}} << (s*S)))
                       | ({{(W-S){1'b0}}, sum[S-1:0] | (pmode[s] ? (sa | sb) & sm : '0)} << (s*S));
        assign ncy[s+1] = sum[S];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k <= NSEG; k++) begin
                pv[k] <= 1'b0;
                pc[k] <= '0;
                pcy[k] <= 1'b0;
            end
            for (int k = 0; k < NSEG; k++) begin
                pa[k] <= '0;
                pb[k] <= '0;
                pm[k] <= '0;
                pmode[k] <= 1'b0;
            end
            povf <= 1'b0;
        end else if (adv) begin
            pv[0] <= in_valid;
            pc[0] <= '0;
            pcy[0] <= 1'b0;
            pa[0] <= a;
            pb[0] <= b;
            pm[0] <= mask_in;
            pmode[0] <= apx_mode;
            for (int k = 1; k <= NSEG; k++) begin
                pv[k] <= pv[k-1];
                pc[k] <= nc[k];
                pcy[k] <= ncy[k];
            end
            for (int k = 1; k < NSEG; k++) begin
                pa[k] <= pa[k-1];
                pb[k] <= pb[k-1];
                pm[k] <= pm[k-1];
                pmode[k] <= pmode[k-1];
            end
            // A fully truncated msb means t = W, where overflow is defined as 0.
            povf <= ~pm[NSEG-1][W-1] & (pa[NSEG-1][W-1] == pb[NSEG-1][W-1])
                  & (nc[NSEG][W-1] != pa[NSEG-1][W-1]);
        end
    end
endmodule

// File: tb/tb_config_int_add_apx_pipe.sv
// tb_config_int_add_apx_pipe: scoreboard bench for the approximate adder pipeline;
// expected results are queued at acceptance and popped by an independent output monitor.
module tb_config_int_add_apx_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        apx_ctl = 1'b0;
    logic        apx_mode = 1'b0;
    logic        out_ready = 1'b1;
    logic [2:0]  apx_lvl = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready, out_valid, cout, ovf;
    logic [31:0] c;
    logic [33:0] exp_q[$];
    int          checks = 0;
    int          failures = 0;
    logic        rand_done = 1'b0;
    logic        stalled = 1'b0;
    logic [33:0] held;

    always #5 clk = ~clk;

    config_int_add_apx_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .apx_ctl(apx_ctl), .apx_mode(apx_mode), .apx_lvl(apx_lvl),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .c(c), .cout(cout), .ovf(ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: {cout, ovf, c} from plain shift/add arithmetic on 64-bit values.
    function automatic logic [33:0] model(input logic [31:0] xa, input logic [31:0] xb,
                                          input logic ctl, input logic mode, input logic [2:0] lvl);
        int          t;
        logic [63:0] s, lo;
        logic [31:0] r;
        logic        ov;
        t = ctl ? 4 * ((lvl > 3'd4) ? 4 : int'(lvl)) : 0;
        lo = (64'd1 << t) - 64'd1;
        if (mode) s = ((64'(xa) >> t) + (64'(xb) >> t)) << t;
        else s = ((64'(xa) >> t) << t) + ((64'(xb) >> t) << t);
        r = s[31:0] | (mode ? (xa | xb) & lo[31:0] : 32'd0);
        ov = (t < 32) && (xa[31] == xb[31]) && (r[31] != xa[31]);
        return {s[32], ov, r};
    endfunction

    task automatic offer(input logic [31:0] xa, input logic [31:0] xb, input logic ctl,
                         input logic mode, input logic [2:0] lvl, input logic [33:0] e);
        int   n = 0;
        logic acc = 1'b0;
        a = xa;
        b = xb;
        apx_ctl = ctl;
        apx_mode = mode;
        apx_lvl = lvl;
        in_valid = 1'b1;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (acc) exp_q.push_back(e);
        else chk("accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic offer_rand();
        logic [31:0] xa, xb;
        logic        ctl, mode;
        logic [2:0]  lvl;
        xa = ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : $urandom;
        xb = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        ctl = 1'($urandom_range(0, 1));
        mode = 1'($urandom_range(0, 1));
        lvl = 3'($urandom_range(0, 7));
        offer(xa, xb, ctl, mode, lvl, model(xa, xb, ctl, mode, lvl));
    endtask

    task automatic latency(input string name);
        int   n = 0;
        logic seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = out_valid;
        end
        chk(name, 64'(n), 64'd5);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic backpressure();
        out_ready = 1'b0;
        fork
            for (int i = 0; i < 8; i++) offer_rand();
            begin
                int n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_first_valid", 64'(out_valid), 64'd1);
                repeat (6) @(negedge clk);
                chk("bp_in_ready_stall", 64'(in_ready), 64'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
    endtask

    task automatic reset_mid();
        for (int i = 0; i < 3; i++) offer_rand();
        repeat (2) @(posedge clk);
        #3;
        chk("pre_reset_valid", 64'(out_valid), 64'd1);
        rst = 1'b0;
        #1;
        chk("mid_reset_valid", 64'(out_valid), 64'd0);
        chk("mid_reset_c", 64'(c), 64'd0);
        chk("mid_reset_cout", 64'(cout), 64'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        offer(32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 3'd0, {1'b0, 1'b0, 32'h0000_5555});
        latency("lat_after_reset");
        drain("reset_drain");
    endtask

    task automatic random_phase();
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    offer_rand();
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("rand_drain");
    endtask

    // Output monitor: compares on consumption, checks hold behaviour while stalled.
    always @(negedge clk) begin
        logic [33:0] got, e;
        got = {cout, ovf, c};
        if (!rst) stalled = 1'b0;
        else if (out_valid && !out_ready) begin
            if (stalled) chk("stall_hold", 64'(got), 64'(held));
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            held = got;
            stalled = 1'b1;
        end else begin
            stalled = 1'b0;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%h required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 64'(got), 64'(e));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        rst = 1'b0;
        #1;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_c", 64'(c), 64'd0);
        chk("reset_cout", 64'(cout), 64'd0);
        chk("reset_ovf", 64'(ovf), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        offer(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 3'd0, {1'b0, 1'b0, 32'h0001_0000});
        latency("lat_exact");
        drain("exact_drain");
        offer(32'h0001_FFFF, 32'h0000_0001, 1'b1, 1'b0, 3'd4, {1'b0, 1'b0, 32'h0001_0000});
        offer(32'h0001_FFFF, 32'h0000_0001, 1'b1, 1'b0, 3'd7, {1'b0, 1'b0, 32'h0001_0000});
        offer(32'h0000_01FF, 32'h0000_0001, 1'b1, 1'b1, 3'd2, {1'b0, 1'b0, 32'h0000_01FF});
        offer(32'h0000_01FF, 32'h0000_0001, 1'b0, 1'b1, 3'd2, {1'b0, 1'b0, 32'h0000_0200});
        offer(32'h0000_00F0, 32'h0000_000F, 1'b1, 1'b1, 3'd2, {1'b0, 1'b0, 32'h0000_00FF});
        offer(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 3'd0, {1'b0, 1'b1, 32'h8000_0000});
        offer(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 3'd0, {1'b1, 1'b0, 32'h0000_0000});
        drain("directed_drain");
        backpressure();
        reset_mid();
        random_phase();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/config_int_add_apx_pipe.md
Name: config_int_add_apx_pipe

Overview:
- Next-generation configurable approximate integer adder.
- Generalises the fixed 16-bit input-mux truncation adder in four ways:
  - the truncation width is selected at runtime, per operation;
  - a second approximation mode (lower-part OR) is added;
  - the datapath is a parametrised segmented pipeline;
  - operands and results move through valid/ready handshakes.
- Sits between operand producers and the accuracy-evaluation results logger in the approximate-operator test harness.

Parameters:
- DATA_PATH_BITWIDTH, 32, operand/result width W; must be a multiple of SEG_BITWIDTH.
- SEG_BITWIDTH, 8, width of one carry-ripple pipeline segment; number of segments NSEG = W/SEG_BITWIDTH.
- TRUNC_STEP, 4, bits truncated per apx_lvl increment.
- MAX_TRUNC_BITWIDTH, 16, maximum truncated LSBs; must be a multiple of TRUNC_STEP and <= W.
- LVL_W, 3, width of apx_lvl.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous reset, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair this cycle.
- apx_ctl  in  1  0 = exact add, 1 = approximate; sampled with operands.
- apx_mode  in  1  0 = truncation (inMux zeroing), 1 = lower-part OR; sampled with operands.
- apx_lvl  in  LVL_W  truncated bits = min(apx_lvl, MAX_TRUNC_BITWIDTH/TRUNC_STEP) * TRUNC_STEP.
- a  in  W  operand A.
- b  in  W  operand B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- c  out  W  result.
- cout  out  1  unsigned carry out of bit W-1.
- ovf  out  1  two's-complement overflow.

Behaviour:
- Reset (rst=0, asynchronous):
  - all stage valid bits clear; out_valid=0, c=0, cout=0, ovf=0.
  - in_ready=1 from the first cycle after release.
- Handshake:
  - Global advance = !out_valid | out_ready.
  - in_ready = advance, combinational; there is no combinational path from in_valid to in_ready.
  - An operand pair is accepted when in_valid & in_ready.
  - A result is consumed when out_valid & out_ready.
  - While out_valid=1 and out_ready=0, every stage holds and c/cout/ovf stay stable.
- Approximation:
  - Truncated width t is computed at acceptance; apx_ctl=0 forces t=0.
  - apx_lvl values above MAX_TRUNC_BITWIDTH/TRUNC_STEP clamp to the maximum.
  - mode 0: a_t, b_t = a, b with bits [t-1:0] zeroed; c = (a_t + b_t) mod 2^W.
  - mode 1: c[t-1:0] = a[t-1:0] | b[t-1:0]; the upper part adds a[W-1:t] + b[W-1:t] with carry-in 0.
  - Both modes: no carry propagates out of the low t bits.
  - t, mode and apx_ctl travel down the pipeline with their data, so consecutive operations may use different settings with no bubble or drain.
- Pipeline:
  - Stage k (k=0..NSEG-1) adds segment k using the carry registered by stage k-1; stage 0 carry-in = 0.
  - Unprocessed upper segments and finished lower result segments are skewed through registers.
  - A segment lying wholly inside the truncated region produces zeros (mode 0) or the OR (mode 1), and carry 0.
  - A segment straddling the boundary t applies the bitwise split.
  - Latency: result appears on out_valid exactly NSEG cycles after acceptance when not stalled. With defaults, acceptance at edge n gives out_valid at edge n+4.
  - Throughput: one operation per cycle; strict in-order delivery.
- Flags:
  - cout = carry out of the top segment.
  - ovf = (msb of effective A == msb of effective B) && (msb c != msb of effective A). Effective operands are a_t/b_t in mode 0 and a/b in mode 1 with t < W.
- Boundary conditions:
  - t = W (legal only if MAX_TRUNC_BITWIDTH=W): mode 0 gives c=0; mode 1 gives c=a|b; cout=0, ovf=0.
  - Accept and consume in the same cycle with a full pipe: both occur, no loss.
  - Reset asserted mid-stream: in-flight data is discarded and no partial result is emitted after release.
  - out_ready=1 while out_valid=0: no effect.

Test Plan:
- Exact add: apx_ctl=0, a=0x0000FFFF, b=0x00000001 -> 4 cycles later c=0x00010000, cout=0, ovf=0.
- Truncation, lvl=4 (t=16), mode 0: a=0x0001FFFF, b=0x00000001 -> c=0x00010000 (exact result would be 0x00020000). Repeat with lvl=7 -> identical result (clamp).
- Lower-part OR, lvl=2 (t=8), mode 1: a=0x000001FF, b=0x00000001 -> c=0x000001FF. Then a=0x000000F0, b=0x0000000F -> c=0x000000FF. Issued back-to-back with an exact op between them: each result matches its own settings, no bubbles.
- Flags, exact: a=0x7FFFFFFF, b=1 -> c=0x80000000, ovf=1, cout=0. a=0xFFFFFFFF, b=1 -> c=0, cout=1, ovf=0.
- Backpressure: stream 8 ops at one per cycle; hold out_ready=0 for 6 cycles after the first out_valid -> in_ready=0 during the stall, c stable, all 8 results delivered in order, none dropped or duplicated.
- Async reset: drop rst low mid-cycle with 3 ops in flight -> out_valid=0 and c=0 immediately. After release, a new op returns after exactly 4 cycles and no stale result appears.
